// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store unit between ALU and writeback.
// Misalignment trapping is selected by MEM_MISALIGN_TRAP_EN in the top module.
package mem_access_unit_pkg;

    localparam int cXLEN         = 32;
    localparam int cAddrWidth    = 32;
    localparam int cRegAddrWidth = 5;

    typedef enum logic [2:0] {
        eLB  = 3'b000,
        eLH  = 3'b001,
        eLW  = 3'b010,
        eLBU = 3'b100,
        eLHU = 3'b101
    } tMemOpType;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        WB   = 2'd3
    } tMemState;

    typedef struct packed {
        logic [cAddrWidth-1:0]    addr;
        logic [cXLEN-1:0]         data;
        tMemOpType                opType;
        logic                     read;
        logic                     write;
        logic [cRegAddrWidth-1:0] rdAddr;
    } tMemReq;

    function automatic logic is_valid_op(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
               (op == 3'b100) || (op == 3'b101);
    endfunction

    function automatic logic is_misaligned(input tMemOpType op, input logic [1:0] offset);
        case (op)
            eLH, eLHU: return offset[0];
            eLW:       return offset != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

    // Natural alignment for the access size: halves drop bit 0, words drop both bits.
    function automatic logic [1:0] align_offset(input tMemOpType op, input logic [1:0] offset);
        case (op)
            eLH, eLHU: return {offset[1], 1'b0};
            eLW:       return 2'b00;
            default:   return offset;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: byte enables and replicated store data on the way out,
// lane extraction with sign/zero extension on the way back.
module lsu_lane_align
    import mem_access_unit_pkg::*;
(
    input  tMemOpType        op_type,
    input  logic [1:0]       offset,
    input  logic [cXLEN-1:0] store_data,
    input  logic [cXLEN-1:0] load_word,
    output logic [3:0]       be,
    output logic [cXLEN-1:0] wdata,
    output logic [cXLEN-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be    = 4'b0000;
        wdata = store_data;
        case (op_type)
            eLB, eLBU: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            eLH, eLHU: begin
                be    = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            eLW: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            default: begin
                be    = 4'b0000;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        byte_sel = load_word[7:0];
        case (offset)
            2'd0:    byte_sel = load_word[7:0];
            2'd1:    byte_sel = load_word[15:8];
            2'd2:    byte_sel = load_word[23:16];
            default: byte_sel = load_word[31:24];
        endcase
        half_sel = offset[1] ? load_word[31:16] : load_word[15:0];
    end

    always_comb begin
        load_data = load_word;
        case (op_type)
            eLB:     load_data = {{24{byte_sel[7]}}, byte_sel};
            eLBU:    load_data = {24'd0, byte_sel};
            eLH:     load_data = {{16{half_sel[15]}}, half_sel};
            eLHU:    load_data = {16'd0, half_sel};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: runs one memOp at a time on the data-memory req/gnt/rvalid bus.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module mem_access_unit #(
    parameter int cXLEN         = 32,
    parameter int cAddrWidth    = 32,
    parameter int cRegAddrWidth = 5
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic                     iRead,
    input  logic                     iWrite,
    input  logic [2:0]               iOpType,
    input  logic [cAddrWidth-1:0]    iAddr,
    input  logic [cXLEN-1:0]         iData,
    input  logic [cRegAddrWidth-1:0] iRdAddr,
    output logic                     oStall,
    output logic                     oDmemReq,
    output logic                     oDmemWe,
    output logic [cAddrWidth-1:0]    oDmemAddr,
    output logic [3:0]               oDmemBe,
    output logic [cXLEN-1:0]         oDmemWdata,
    input  logic                     iDmemGnt,
    input  logic                     iDmemRvalid,
    input  logic [cXLEN-1:0]         iDmemRdata,
    output logic                     oRegDv,
    output logic [cRegAddrWidth-1:0] oRegAddr,
    output logic [cXLEN-1:0]         oRegData,
    output logic                     oMisalign,
    output logic [1:0]               oDbgState
);

    import mem_access_unit_pkg::*;

    // Handshake: a request is taken on a rising edge where iValid=1 and oReady=1;
    // the memory takes the bus request on an edge where oDmemReq=1 and iDmemGnt=1.
    tMemState              state, state_next;
    tMemReq                req_q;
    logic [cXLEN-1:0]      load_q;
    tMemOpType             op_in;
    logic                  accept;
    logic                  issue;
    logic [cAddrWidth-1:0] addr_in;
    logic [3:0]            lane_be;
    logic [cXLEN-1:0]      lane_wdata;
    logic [cXLEN-1:0]      lane_load;

    assign op_in  = tMemOpType'(iOpType);
    assign accept = (state == IDLE) && iValid && (iRead || iWrite) && is_valid_op(iOpType);

`ifdef MEM_MISALIGN_TRAP_EN
    logic trap;
    logic misalign_q;

    assign trap    = accept && is_misaligned(op_in, iAddr[1:0]);
    assign issue   = accept && !trap;
    assign addr_in = iAddr;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= trap;
        end
    end

    assign oMisalign = misalign_q;
`else
    assign issue     = accept;
    assign addr_in   = {iAddr[cAddrWidth-1:2], align_offset(op_in, iAddr[1:0])};
    assign oMisalign = 1'b0;
`endif

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = REQ;
            REQ:     if (iDmemGnt) state_next = req_q.read ? RESP : IDLE;
            RESP:    if (iDmemRvalid) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A simultaneous read+write request is treated as a load.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            req_q  <= '0;
            load_q <= '0;
        end else begin
            if (issue) begin
                req_q.addr   <= addr_in;
                req_q.data   <= iData;
                req_q.opType <= op_in;
                req_q.read   <= iRead;
                req_q.write  <= iWrite && !iRead;
                req_q.rdAddr <= iRdAddr;
            end
            if ((state == RESP) && iDmemRvalid) begin
                load_q <= lane_load;
            end
        end
    end

    lsu_lane_align u_lane_align (
        .op_type    (req_q.opType),
        .offset     (req_q.addr[1:0]),
        .store_data (req_q.data),
        .load_word  (iDmemRdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    // Bus and writeback fields are zeroed outside their own state so idle outputs stay quiet.
    always_comb begin
        oReady     = 1'b0;
        oStall     = 1'b1;
        oDmemReq   = 1'b0;
        oDmemWe    = 1'b0;
        oDmemAddr  = '0;
        oDmemBe    = 4'b0000;
        oDmemWdata = '0;
        oRegDv     = 1'b0;
        oRegAddr   = '0;
        oRegData   = '0;
        case (state)
            IDLE: begin
                oReady = 1'b1;
                oStall = 1'b0;
            end
            REQ: begin
                oDmemReq   = 1'b1;
                oDmemWe    = req_q.write;
                oDmemAddr  = {req_q.addr[cAddrWidth-1:2], 2'b00};
                oDmemBe    = lane_be;
                oDmemWdata = lane_wdata;
            end
            WB: begin
                oRegDv   = (req_q.rdAddr != '0);
                oRegAddr = req_q.rdAddr;
                oRegData = load_q;
            end
            default: ;
        endcase
    end

    assign oDbgState = state;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumer side of the ALU's memOp/regOp interface: takes a registered load/store request and runs it on the data-memory request/grant/response bus.
- Generates byte enables and lane-shifted store data.
- Extracts and sign- or zero-extends load data and issues the register writeback.
- Stalls the pipeline while an access is outstanding; sits between ALU and writeback stage.

Parameters:
- cXLEN, 32, data/register width (only 32 supported).
- cAddrWidth, 32, byte-address width.
- cRegAddrWidth, 5, register index width.

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  reset, asynchronous, active-low.
- iValid  in  1  request valid (ALU memOp read|write asserted).
- oReady  out  1  unit idle, request accepted this cycle when iValid=1.
- iRead  in  1  load request.
- iWrite  in  1  store request.
- iOpType  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- iAddr  in  cAddrWidth  byte address.
- iData  in  cXLEN  store data (rs2).
- iRdAddr  in  cRegAddrWidth  load destination register.
- oStall  out  1  pipeline hold.
- oDmemReq  out  1  bus request.
- oDmemWe  out  1  1 = write.
- oDmemAddr  out  cAddrWidth  word-aligned address ({iAddr[31:2],2'b00}).
- oDmemBe  out  4  byte enables.
- oDmemWdata  out  cXLEN  lane-aligned write data.
- iDmemGnt  in  1  request accepted by memory.
- iDmemRvalid  in  1  read data valid.
- iDmemRdata  in  cXLEN  read word.
- oRegDv  out  1  writeback valid, one-cycle pulse.
- oRegAddr  out  cRegAddrWidth  writeback register.
- oRegData  out  cXLEN  extended load result.
- oMisalign  out  1  one-cycle misalignment flag.

Behaviour:
- Reset: state IDLE. Every output 0 except oReady=1.
- FSM states: IDLE, REQ, RESP, WB.
- IDLE:
  - oReady=1, oStall=0.
  - iValid & (iRead|iWrite) → capture op, addr, data, rd → REQ next cycle.
  - iRead&iWrite both set → treated as load.
  - Invalid iOpType (011, 110, 111) → dropped, no bus activity, stays IDLE.
- REQ:
  - oDmemReq=1; address, we, be and wdata held stable until iDmemGnt.
  - Gnt on a store → IDLE.
  - Gnt on a load → RESP.
- RESP:
  - Wait for iDmemRvalid, which is never earlier than the cycle after gnt.
  - Rvalid → register extracted data → WB.
- WB: oRegDv=1 for one cycle, unless rd=0 (then oRegDv=0). Then → IDLE.
- oStall = (state≠IDLE). oReady = (state==IDLE).
- Minimum latency:
  - Load: accepted at cycle 0, req at 1, gnt at 1, rvalid at 2, oRegDv at 3.
  - Store: accepted at 0, req/gnt at 1.
- Byte enables by offset o = iAddr[1:0]:
  - b: 4'b0001<<o.
  - h: 4'b0011<<o.
  - w: 4'b1111.
- Store data: b → byte replicated to all 4 lanes; h → half replicated to both halves; w → as is.
- Load extraction:
  - b/bu: byte at lane o.
  - h/hu: half at lane o[1].
  - b/h sign-extend from bit 7/15; bu/hu zero-extend.
- Misaligned: h with o[0]=1, or w with o≠0.
- No timeout. Bus stalls indefinitely hold the FSM.
- iValid outside IDLE is ignored; the upstream holds the request while oStall=1.
- Async reset mid-access: FSM returns to IDLE immediately and oDmemReq drops. A late rvalid in IDLE is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request is not issued; state stays IDLE.
  - oMisalign pulses 1 cycle after acceptance; no writeback.
- Undefined:
  - The low address bits are forced to natural alignment (h: o[0]=0, w: o=0) and the access proceeds.
  - oMisalign is tied 0.

Decomposition:
- corePckg additions:
  - tMemOpType enum (eLB=000, eLH, eLW, eLBU=100, eLHU).
  - tMemState enum.
  - tMemReq struct {addr, data, opType, read, write, rdAddr}.
  - cXLEN reused.
- Sub-module lsu_lane_align (combinational): byte-enable/write-data generation plus load extraction/extension; instantiated once.

Test Plan:
- Store sb, addr 0x103, data 0xAABBCCDD, gnt immediate → oDmemAddr 0x100, Be 4'b1000, Wdata 0xDDDDDDDD, oStall high 1 cycle.
- Load lb, addr 0x102, rdata 0x00F30000, rd=5 → oRegData 0xFFFFFFF3, oRegDv at cycle 3. Repeat with lbu → 0x000000F3.
- Load lhu, addr 0x2, rdata 0x8001_1234, gnt delayed 3 cycles, rvalid 2 cycles after gnt → oRegData 0x00008001; request held stable, oStall high throughout.
- Load lw, rd=0 → bus access performed, oRegDv stays 0.
- lh at 0x101: with MEM_MISALIGN_TRAP_EN → oMisalign pulse, no oDmemReq. Without → addr 0x100, Be 4'b0011.
- Reset asserted in RESP, then rvalid after release → all outputs 0, IDLE, no writeback.
